// File: rtl/mutex_access_arbiter_pkg.sv
// Shared types and field layout for the mutex access arbiter and its round-robin picker.
package mutex_access_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_LOCK,
        RD_CHECK,
        BACKOFF,
        GRANTED,
        WR_FREE
    } state_t;

    localparam int OWNER_MSB = 31;
    localparam int OWNER_LSB = 16;
    localparam int VALUE_MSB = 15;
    localparam int VALUE_LSB = 0;

    localparam logic ADDR_MUTEX = 1'b0;
    localparam logic ADDR_RESET = 1'b1;

    typedef struct packed {
        logic        address;
        logic        chipselect;
        logic        write;
        logic        read;
        logic [31:0] writedata;
    } mutex_cmd_t;

    function automatic mutex_cmd_t cmd_write(input logic [15:0] owner, input logic [15:0] value);
        mutex_cmd_t c;
        c            = '0;
        c.address    = ADDR_MUTEX;
        c.chipselect = 1'b1;
        c.write      = 1'b1;
        c.writedata  = {owner, value};
        return c;
    endfunction

    function automatic mutex_cmd_t cmd_read();
        mutex_cmd_t c;
        c            = '0;
        c.address    = ADDR_MUTEX;
        c.chipselect = 1'b1;
        c.read       = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mutex_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        j     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ))
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            j = sum[IDX_W-1:0];
            if (req[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mutex_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto one hardware mutex slave: lock, confirm by readback,
// hold a one-hot grant until release, then free the mutex.
module mutex_access_arbiter
    import mutex_access_arbiter_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] OWNER_BASE     = 16'h0010,
    parameter logic [15:0] LOCK_VALUE     = 16'h0001,
    parameter int          BACKOFF_CYCLES = 8,
    parameter int          MAX_TRIES      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] release_pulse,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               fail_pulse,
    output logic               m_address,
    output logic               m_chipselect,
    output logic               m_write,
    output logic               m_read,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int BO_W  = $clog2(BACKOFF_CYCLES + 1);

    state_t           state;
    mutex_cmd_t       cmd;
    logic [IDX_W-1:0] rr_ptr, cur, pick_idx;
    logic             pick_vld;
    logic [TRY_W-1:0] try_cnt, try_inc;
    logic [BO_W-1:0]  backoff_cnt;
    logic [15:0]      cur_owner;
    logic             rd_ok;

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    function automatic logic [15:0] owner_of(input logic [IDX_W-1:0] i);
        return OWNER_BASE + 16'(i);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    assign cur_owner = owner_of(cur);
    assign try_inc   = try_cnt + TRY_W'(1);
    assign rd_ok     = (m_readdata[OWNER_MSB:OWNER_LSB] == cur_owner) &&
                       (m_readdata[VALUE_MSB:VALUE_LSB] != '0);

    assign m_address    = cmd.address;
    assign m_chipselect = cmd.chipselect;
    assign m_write      = cmd.write;
    assign m_read       = cmd.read;
    assign m_writedata  = cmd.writedata;

    // Bus strobes and fail_pulse default low each cycle; each state sets what the next one drives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= '0;
            rr_ptr      <= '0;
            cur         <= '0;
            try_cnt     <= '0;
            backoff_cnt <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            fail_pulse  <= 1'b0;
        end else begin
            cmd        <= '0;
            fail_pulse <= 1'b0;
            case (state)
                IDLE: if (pick_vld) begin
                    cur   <= pick_idx;
                    cmd   <= cmd_write(owner_of(pick_idx), LOCK_VALUE);
                    busy  <= 1'b1;
                    state <= WR_LOCK;
                end
                WR_LOCK: begin
                    cmd   <= cmd_read();
                    state <= RD_CHECK;
                end
                RD_CHECK: begin
                    if (rd_ok && req[cur]) begin
                        grant[cur] <= 1'b1;
                        try_cnt    <= '0;
                        state      <= GRANTED;
                    end else if (rd_ok) begin
                        cmd   <= cmd_write(cur_owner, 16'h0000);
                        state <= WR_FREE;
                    end else if (try_inc == TRY_W'(MAX_TRIES)) begin
                        fail_pulse <= 1'b1;
                        rr_ptr     <= next_ptr(cur);
                        try_cnt    <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        try_cnt     <= try_inc;
                        backoff_cnt <= '0;
                        state       <= BACKOFF;
                    end
                end
                BACKOFF: begin
                    if (!req[cur]) begin
                        rr_ptr  <= next_ptr(cur);
                        try_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (backoff_cnt == BO_W'(BACKOFF_CYCLES - 1)) begin
                        cmd   <= cmd_write(cur_owner, LOCK_VALUE);
                        state <= WR_LOCK;
                    end else begin
                        backoff_cnt <= backoff_cnt + BO_W'(1);
                    end
                end
                GRANTED: if (release_pulse[cur] || !req[cur]) begin
                    grant <= '0;
                    cmd   <= cmd_write(cur_owner, 16'h0000);
                    state <= WR_FREE;
                end
                WR_FREE: begin
                    rr_ptr  <= next_ptr(cur);
                    try_cnt <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
